// File: rtl/fmc_psram_slave.sv
// FMC/PSRAM-style multiplexed A/D slave: address phase, programmable latency, then byte-lane
// write / read bursts with wrapping addresses. Define FMC_PSRAM_SLAVE_WAIT_EN to drive wait_o.
module fmc_psram_slave #(
  parameter int AddrWidth = 16,
  parameter int DataWidth = 16,
  parameter int MemDepth  = 256,
  parameter int Latency   = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  inout  wire  [DataWidth-1:0]   data_io,
  input  logic                   cs_ni,
  input  logic                   oe_ni,
  input  logic                   we_ni,
  input  logic                   adv_ni,
  input  logic [DataWidth/8-1:0] nbl_ni,
  output logic                   wait_o
);
  localparam int NumLanes = DataWidth / 8;
  localparam int MB       = $clog2(MemDepth);
  localparam int CW       = $clog2(Latency + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LATENCY = 2'd1;
  localparam logic [1:0] DATA    = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] mem [MemDepth];

  logic          addr_valid, rd, wr, beat_rd, beat_wr;
  logic [MB-1:0] idx;

  assign addr_valid = !cs_ni && !adv_ni;
  assign rd         = !cs_ni && adv_ni && we_ni && !oe_ni;
  assign wr         = !cs_ni && adv_ni && !we_ni;
  assign idx        = addr_q[MB-1:0];
  assign beat_rd    = (state_q == DATA) && rd;
  assign beat_wr    = (state_q == DATA) && wr;

  // A new address phase restarts the transaction from any state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    if (cs_ni) begin
      state_d = IDLE;
    end else if (addr_valid) begin
      addr_d = data_io[AddrWidth-1:0];
      if (Latency == 1) begin
        state_d = DATA;
      end else begin
        state_d = LATENCY;
        cnt_d   = CW'(Latency - 1);
      end
    end else begin
      case (state_q)
        LATENCY: begin
          if (cnt_q == CW'(1)) state_d = DATA;
          else                 cnt_d   = cnt_q - 1'b1;
        end
        DATA: begin
          if (rd || wr) addr_d = addr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Memory is deliberately not reset; a beat coinciding with reset is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && beat_wr) begin
      for (int i = 0; i < NumLanes; i++) begin
        if (!nbl_ni[i]) mem[idx][8*i +: 8] <= data_io[8*i +: 8];
      end
    end
  end

  assign data_io = (beat_rd && !rst_i) ? mem[idx] : {DataWidth{1'bz}};

`ifdef FMC_PSRAM_SLAVE_WAIT_EN
  assign wait_o = (state_q == LATENCY);
`else
  assign wait_o = 1'b0;
`endif

endmodule

// File: tb/tb_fmc_psram_slave.sv
// Bench for fmc_psram_slave: vector table, hand corner sequences and random bursts vs a word-array model.
module tb_fmc_psram_slave;
  localparam int L = 3;
`ifdef FMC_PSRAM_SLAVE_WAIT_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cs_n = 1'b1, oe_n = 1'b1, we_n = 1'b1, adv_n = 1'b1;
  logic [1:0]  nbl_n = 2'b11;
  logic        tb_en = 1'b0;
  logic [15:0] tb_dat = '0;
  tri1  [15:0] bus;
  logic        wt;
  assign bus = tb_en ? tb_dat : 16'hzzzz;

  logic        cs4 = 1'b1, oe4 = 1'b1, we4 = 1'b1, adv4 = 1'b1;
  logic [1:0]  nbl4 = 2'b11;
  logic        en4 = 1'b0;
  logic [15:0] dat4 = '0;
  tri1  [15:0] bus4;
  logic        wt4;
  assign bus4 = en4 ? dat4 : 16'hzzzz;

  fmc_psram_slave #(.AddrWidth(16), .DataWidth(16), .MemDepth(256), .Latency(L)) dut (
    .clk_i(clk), .rst_i(rst), .data_io(bus), .cs_ni(cs_n), .oe_ni(oe_n),
    .we_ni(we_n), .adv_ni(adv_n), .nbl_ni(nbl_n), .wait_o(wt));

  fmc_psram_slave #(.AddrWidth(16), .DataWidth(16), .MemDepth(256), .Latency(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .data_io(bus4), .cs_ni(cs4), .oe_ni(oe4),
    .we_ni(we4), .adv_ni(adv4), .nbl_ni(nbl4), .wait_o(wt4));

  int checks = 0;
  int fails  = 0;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are checked at the falling edge.
  task automatic drive(bit cs, bit adv, bit we, bit oe, logic [1:0] nbl, bit en, logic [15:0] d);
    @(posedge clk); #1;
    cs_n = cs; adv_n = adv; we_n = we; oe_n = oe; nbl_n = nbl; tb_en = en; tb_dat = d;
    @(negedge clk);
  endtask

  task automatic drive4(bit cs, bit adv, bit we, bit oe, bit en, logic [15:0] d);
    @(posedge clk); #1;
    cs4 = cs; adv4 = adv; we4 = we; oe4 = oe; nbl4 = 2'b00; en4 = en; dat4 = d;
    @(negedge clk);
  endtask

  // Reference model: the memory as a plain word array indexed by address modulo depth.
  logic [15:0] mm [256];
  logic [15:0] wd [64];
  logic [1:0]  wn [64];
  int          gap [64];
  logic [15:0] rd_got [64];

  task automatic txn(bit wr, logic [15:0] a, int n, bit junk);
    logic [15:0] ad;
    ad = a;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, a);
    for (int c = 1; c < L; c++) begin
      if (junk && c[0]) begin
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 16'h0BAD);
      end else begin
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 16'h0);
        chk("lat_bus", bus, 16'hFFFF);
      end
      chk("lat_wait", 16'(wt), 16'(WEN));
    end
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < gap[k]; g++) begin
        drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 16'h0);
        chk("gap_bus", bus, 16'hFFFF);
      end
      if (wr) begin
        drive(1'b0, 1'b1, 1'b0, 1'b1, wn[k], 1'b1, wd[k]);
        for (int i = 0; i < 2; i++)
          if (!wn[k][i]) mm[ad[7:0]][8*i +: 8] = wd[k][8*i +: 8];
      end else begin
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 16'h0);
        rd_got[k] = bus;
        chk("rd_data", bus, mm[ad[7:0]]);
      end
      chk("data_wait", 16'(wt), 16'h0);
      ad = ad + 16'd1;
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 16'h0);
    chk("idle_bus", bus, 16'hFFFF);
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [15:0] d;
    logic [1:0]  nbl;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [11];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 16'h0020, 16'hBEEF, 2'b00, 16'h0};
    tbl[1]  = '{1'b1, 16'h0020, 16'h1234, 2'b01, 16'h0};
    tbl[2]  = '{1'b0, 16'h0020, 16'h0,    2'b11, 16'h12EF};
    tbl[3]  = '{1'b1, 16'h0030, 16'h0A0B, 2'b00, 16'h0};
    tbl[4]  = '{1'b1, 16'h0030, 16'h5555, 2'b11, 16'h0};
    tbl[5]  = '{1'b0, 16'h0030, 16'h0,    2'b11, 16'h0A0B};
    tbl[6]  = '{1'b1, 16'h01FF, 16'h7777, 2'b00, 16'h0};
    tbl[7]  = '{1'b0, 16'h00FF, 16'h0,    2'b11, 16'h7777};
    tbl[8]  = '{1'b1, 16'h0031, 16'h0000, 2'b00, 16'h0};
    tbl[9]  = '{1'b1, 16'h0031, 16'hCAFE, 2'b10, 16'h0};
    tbl[10] = '{1'b0, 16'h0031, 16'h0,    2'b11, 16'h00FE};
    for (int k = 0; k < 64; k++) gap[k] = 0;

    // Reset: bus tristated even with a read strobe present.
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 16'h0);
    chk("rst_bus", bus, 16'hFFFF);
    chk("rst_wait", 16'(wt), 16'h0);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 16'h0);

    // Preload every word so the model is fully known.
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 64; k++) begin
        logic [7:0] w;
        w = 8'(b * 64 + k);
        wd[k] = {w ^ 8'h5A, w};
        wn[k] = 2'b00;
      end
      txn(1'b1, 16'(b * 64), 64, 1'b0);
    end

    for (int v = 0; v < 11; v++) begin
      wd[0] = tbl[v].d;
      wn[0] = tbl[v].nbl;
      txn(tbl[v].wr, tbl[v].a, 1, 1'b0);
      if (!tbl[v].wr) chk("tbl_read", rd_got[0], tbl[v].exp);
    end

    // Burst write / read back 0x10..0x13.
    for (int k = 0; k < 4; k++) begin wd[k] = 16'hA001 + 16'(k); wn[k] = 2'b00; end
    txn(1'b1, 16'h0010, 4, 1'b0);
    txn(1'b0, 16'h0010, 4, 1'b0);
    for (int k = 0; k < 4; k++) chk("burst_rd", rd_got[k], 16'hA001 + 16'(k));

    // Burst wraps from the last word to word 0.
    for (int k = 0; k < 3; k++) begin wd[k] = 16'hC001 + 16'(k); wn[k] = 2'b00; end
    txn(1'b1, 16'h00FF, 3, 1'b0);
    txn(1'b0, 16'h00FF, 3, 1'b0);
    for (int k = 0; k < 3; k++) chk("wrap_rd", rd_got[k], 16'hC001 + 16'(k));

    // Chip select dropped during latency: nothing written, wait clears.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 16'h0050);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 16'h9999);
    chk("cs_lat_wait", 16'(wt), 16'(WEN));
    drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 16'h9999);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 16'h0);
    chk("cs_idle_wait", 16'(wt), 16'h0);
    chk("cs_idle_bus", bus, 16'hFFFF);
    txn(1'b0, 16'h0050, 1, 1'b0);
    chk("cs_nowrite", rd_got[0], {8'h50 ^ 8'h5A, 8'h50});
    wd[0] = 16'h4040; wn[0] = 2'b00;
    txn(1'b1, 16'h0040, 1, 1'b0);
    txn(1'b0, 16'h0040, 1, 1'b0);
    chk("after_cs_rd", rd_got[0], 16'h4040);

    // Reset on the second beat of a write burst.
    wd[0] = 16'h3C3C; wn[0] = 2'b00;
    txn(1'b1, 16'h0061, 1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 16'h0060);
    for (int c = 1; c < L; c++) drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 16'h1111);
    mm[8'h60] = 16'h1111;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 16'h2222);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 16'h0);
    chk("rstmid_bus", bus, 16'hFFFF);
    chk("rstmid_wait", 16'(wt), 16'h0);
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 16'h0);
    chk("rstidle_bus", bus, 16'hFFFF);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 16'h0);
    txn(1'b0, 16'h0060, 2, 1'b0);
    chk("rst_keep", rd_got[0], 16'h1111);
    chk("rst_drop", rd_got[1], 16'h3C3C);

    // Latency=4 instance: first beat is at edge 4, never earlier.
    drive4(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0005);
    for (int c = 1; c < 4; c++) begin
      drive4(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      chk("l4_wr_wait", 16'(wt4), 16'(WEN));
    end
    drive4(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4444);
    chk("l4_beat_wait", 16'(wt4), 16'h0);
    drive4(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    drive4(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0005);
    for (int c = 1; c < 4; c++) begin
      drive4(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
      chk("l4_lat_bus", bus4, 16'hFFFF);
      chk("l4_rd_wait", 16'(wt4), 16'(WEN));
    end
    drive4(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("l4_rd", bus4, 16'h4444);
    drive4(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("l4_idle_bus", bus4, 16'hFFFF);

    // Random bursts with gaps, partial lanes and ignored latency strobes.
    for (int t = 0; t < 40; t++) begin
      bit          w;
      int          n;
      logic [15:0] a;
      w = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 4);
      a = 16'($urandom);
      for (int k = 0; k < n; k++) begin
        wd[k]  = 16'($urandom);
        if (wd[k] == 16'hFFFF) wd[k] = 16'h7FFF;
        wn[k]  = 2'($urandom);
        gap[k] = ($urandom_range(0, 3) == 0) ? 1 : 0;
      end
      txn(w, a, n, 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 64; k++) gap[k] = 0;
    for (int b = 0; b < 4; b++) txn(1'b0, 16'(b * 64), 64, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
